// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// iteration count and the divide-by-zero quotient.
package div32_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          DIV_ITER = 32;
    localparam logic [31:0] DIVZ_Q   = 32'hFFFF_FFFF;

endpackage

// File: rtl/div32_seq_sub32.sv
// 32-bit subtractor for the divider's trial step, built as a cla32 adder
// (eight cla4 lookahead slices) computing a + ~b + 1.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] p_s;
    logic [3:0] g_s;
    logic [3:0] c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Full lookahead inside the slice; slices are chained by cla32.
    assign c_s[0] = ci;
    assign c_s[1] = g_s[0] | (p_s[0] & ci);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & ci);
    assign co     = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);
    assign s      = p_s ^ c_s;
endmodule

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic [8:0] c_s;

    assign c_s[0] = ci;

    for (genvar i = 0; i < 8; i++) begin : g_slice
        cla4 u_cla4 (
            .a  (a[4*i +: 4]),
            .b  (b[4*i +: 4]),
            .ci (c_s[i]),
            .s  (s[4*i +: 4]),
            .co (c_s[i+1])
        );
    end

    assign co = c_s[8];
endmodule

module sub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] d,
    output logic        co
);
    logic [31:0] b_inv_s;

    assign b_inv_s = ~b;

    // co=1 means a >= b (no borrow).
    cla32 u_cla32 (
        .a  (a),
        .b  (b_inv_s),
        .ci (1'b1),
        .s  (d),
        .co (co)
    );
endmodule

// File: rtl/div32_seq.sv
// Multi-cycle unsigned 32-bit restoring divider: one shift-and-subtract
// iteration per clock with a start/done handshake and held results.
module div32_seq
    import div32_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITER - 1);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    logic             load_s;
    logic             divz_s;
    logic             iter_s;
    logic             finish_s;

    logic             msb_s;
    logic [WIDTH-1:0] rs_s;
    logic [WIDTH-1:0] trial_s;
    logic             co_s;
    logic             accept_s;
    logic [WIDTH-1:0] r_next_s;
    logic [WIDTH-1:0] q_next_s;

    // Shift the remainder/quotient pair left by one before the trial subtract.
    assign msb_s = r_r[WIDTH-1];
    assign rs_s  = {r_r[WIDTH-2:0], q_r[WIDTH-1]};

    sub32 u_sub32 (
        .a  (rs_s),
        .b  (d_r),
        .d  (trial_s),
        .co (co_s)
    );

    // A shifted-out msb means Rs >= 2^32 > D, so the subtract always succeeds.
    assign accept_s = msb_s | co_s;
    assign r_next_s = accept_s ? trial_s : rs_s;
    assign q_next_s = {q_r[WIDTH-2:0], accept_s};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and datapath control strobes.
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        divz_s   = 1'b0;
        iter_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (divisor == {WIDTH{1'b0}}) begin
                        divz_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        load_s  = 1'b1;
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                iter_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Working registers, iteration counter and held results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            d_r         <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else if (load_s) begin
            cnt_r <= {CNT_W{1'b0}};
            q_r   <= dividend;
            r_r   <= {WIDTH{1'b0}};
            d_r   <= divisor;
            dbz_r <= 1'b0;
        end else if (divz_s) begin
            quotient_r  <= DIVZ_Q;
            remainder_r <= dividend;
            dbz_r       <= 1'b1;
        end else if (iter_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
            q_r   <= q_next_s;
            r_r   <= r_next_s;
            if (finish_s) begin
                quotient_r  <= q_next_s;
                remainder_r <= r_next_s;
            end
        end
    end

    assign busy        = (state_r == ST_RUN);
    assign done        = (state_r == ST_DONE);
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div32_seq.sv
// Directed self-checking bench for div32_seq: latency, msb path, back-to-back,
// divide-by-zero, start during RUN and mid-run reset.
module tb_div32_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks;
    int failures;

    div32_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands for one edge, then scramble them; returns at the
    // negedge right after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
    endtask

    // Count busy samples until done is seen, bounded.
    task automatic wait_done(output int busy_cycles, output bit timed_out);
        int n;
        busy_cycles = 0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_cycles++;
            n++;
            @(negedge clk);
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h expected all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int  bc;
        bit  to;
        issue(32'd100, 32'd7);
        wait_done(bc, to);
        checks++;
        if (to || bc != 32) begin
            failures++;
            $display("FAIL basic_latency: busy_cycles=%0d timeout=%b expected 32", bc, to);
        end
        checks++;
        if (busy !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: busy=%b q=%0d r=%0d dbz=%b expected 0/14/2/0",
                     busy, quotient, remainder, div_by_zero);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL basic_hold: done=%b q=%0d r=%0d expected 0/14/2", done, quotient, remainder);
        end
    endtask

    task automatic test_msb_path();
        int bc;
        bit to;
        issue(32'hFFFF_FFFF, 32'h8000_0000);
        wait_done(bc, to);
        checks++;
        if (to || quotient !== 32'd1 || remainder !== 32'h7FFF_FFFF) begin
            failures++;
            $display("FAIL msb_path: q=%h r=%h timeout=%b expected 00000001/7fffffff",
                     quotient, remainder, to);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        bit to;
        issue(32'd3, 32'd10);
        wait_done(bc, to);
        checks++;
        if (to || quotient !== 32'd0 || remainder !== 32'd3) begin
            failures++;
            $display("FAIL b2b_first: q=%0d r=%0d timeout=%b expected 0/3", quotient, remainder, to);
        end
        // Still in the DONE cycle: launch the next operation with no idle gap.
        start    = 1'b1;
        dividend = 32'hFFFF_FFFF;
        divisor  = 32'd1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b expected 1/0", busy, done);
        end
        wait_done(bc, to);
        checks++;
        if (to || bc != 32 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
            failures++;
            $display("FAIL b2b_second: q=%h r=%h busy_cycles=%0d timeout=%b expected ffffffff/0/32",
                     quotient, remainder, bc, to);
        end
    endtask

    task automatic test_div_zero();
        int bc;
        bit to;
        issue(32'd5, 32'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd5
            || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL div_zero: done=%b busy=%b q=%h r=%0d dbz=%b expected 1/0/ffffffff/5/1",
                     done, busy, quotient, remainder, div_by_zero);
        end
        issue(32'd9, 32'd3);
        checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL div_zero_clear: dbz=%b busy=%b expected 0/1", div_by_zero, busy);
        end
        wait_done(bc, to);
        checks++;
        if (to || quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL div_after_zero: q=%0d r=%0d dbz=%b timeout=%b expected 3/0/0",
                     quotient, remainder, div_by_zero, to);
        end
    endtask

    task automatic test_start_during_run();
        int pulses;
        issue(32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(negedge clk);
        start    = 1'b0;
        pulses   = 0;
        for (int i = 0; i < 45; i++) begin
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if (quotient !== 32'd333 || remainder !== 32'd1) begin
                    failures++;
                    $display("FAIL run_ignore_result: q=%0d r=%0d expected 333/1", quotient, remainder);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL run_ignore_pulses: done_pulses=%0d expected 1", pulses);
        end
    endtask

    task automatic test_reset_mid_run();
        int bc;
        bit to;
        int seen;
        issue(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || quotient !== 32'd333) begin
            failures++;
            $display("FAIL mid_run_pre: busy=%b q=%0d expected 1/333", busy, quotient);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL mid_run_reset: busy=%b done=%b dbz=%b q=%0d r=%0d expected all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_run_abort: busy_or_done_cycles=%0d expected 0", seen);
        end
        issue(32'd8, 32'd2);
        wait_done(bc, to);
        checks++;
        if (to || quotient !== 32'd4 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL after_reset: q=%0d r=%0d timeout=%b expected 4/0", quotient, remainder, to);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_msb_path();
        test_back_to_back();
        test_div_zero();
        test_start_during_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
